// File: rtl/operand_demux.sv
// Sequential 1-to-4 operand distributor: fills slots a..d from a tagged word stream
// and presents them as one operand set once every slot holds a fresh value.
module operand_demux #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_sel,
   input  logic signed [WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] a,
   output logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] c,
   output logic signed [WIDTH-1:0] d,
   output logic [3:0]              loaded,
   output logic                    overwrite
);

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                    state_r, state_s;
   logic signed [WIDTH-1:0]   a_r, b_r, c_r, d_r;
   logic signed [WIDTH-1:0]   a_s, b_s, c_s, d_s;
   logic [3:0]                loaded_r, loaded_s;
   logic                      overwrite_r, overwrite_s;

   // Next-state and next-register decode; operands are kept across the FULL->LOAD handshake.
   always_comb begin
      state_s     = state_r;
      loaded_s    = loaded_r;
      overwrite_s = overwrite_r;
      a_s         = a_r;
      b_s         = b_r;
      c_s         = c_r;
      d_s         = d_r;
      case (state_r)
         LOAD: begin
            if (in_valid) begin
               loaded_s = loaded_r | (4'b0001 << in_sel);
               if (loaded_r[in_sel]) begin
                  overwrite_s = 1'b1;
               end else begin
                  overwrite_s = overwrite_r;
               end
               case (in_sel)
                  2'd0:    a_s = in_data;
                  2'd1:    b_s = in_data;
                  2'd2:    c_s = in_data;
                  2'd3:    d_s = in_data;
                  default: a_s = a_r;
               endcase
               if (loaded_s == 4'b1111) begin
                  state_s = FULL;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = LOAD;
            end
         end
         FULL: begin
            if (out_ready) begin
               state_s     = LOAD;
               loaded_s    = 4'b0000;
               overwrite_s = 1'b0;
            end else begin
               state_s = FULL;
            end
         end
         default: begin
            state_s     = LOAD;
            loaded_s    = 4'b0000;
            overwrite_s = 1'b0;
         end
      endcase
   end

   // State and operand registers; reset discards any partial or complete set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= LOAD;
         a_r         <= '0;
         b_r         <= '0;
         c_r         <= '0;
         d_r         <= '0;
         loaded_r    <= 4'b0000;
         overwrite_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         a_r         <= a_s;
         b_r         <= b_s;
         c_r         <= c_s;
         d_r         <= d_s;
         loaded_r    <= loaded_s;
         overwrite_r <= overwrite_s;
      end
   end

   // Handshake signals come straight from the state flop, so no input-to-output path exists.
   assign in_ready  = (state_r == LOAD);
   assign out_valid = (state_r == FULL);
   assign a         = a_r;
   assign b         = b_r;
   assign c         = c_r;
   assign d         = d_r;
   assign loaded    = loaded_r;
   assign overwrite = overwrite_r;

endmodule

// File: tb/tb_operand_demux.sv
// Scoreboard bench for operand_demux: a slot-array reference model predicts every cycle
// and queues each completed operand set for a monitor that checks it when out_valid rises.
module tb_operand_demux;
   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                out_ready = 1'b0;
   logic [1:0]          in_sel = 2'd0;
   logic signed [W-1:0] in_data = '0;
   logic                in_ready, out_valid, overwrite;
   logic signed [W-1:0] a, b, c, d;
   logic [3:0]          loaded;

   operand_demux #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .c(c), .d(d), .loaded(loaded), .overwrite(overwrite)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic signed [W-1:0] a, b, c, d;
      logic                ow;
   } set_t;
   set_t exp_q[$];

   // Reference model: slot contents, fresh flags, sticky overwrite, set-complete flag.
   logic signed [W-1:0] m_slot[4];
   logic [3:0]          m_loaded;
   logic                m_ow;
   logic                m_full;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      m_loaded = 4'b0000;
      m_ow     = 1'b0;
      m_full   = 1'b0;
      exp_q.delete();
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".in_ready"},  64'(in_ready),  64'(!m_full));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
      check({tag, ".loaded"},    64'(loaded),    64'(m_loaded));
      check({tag, ".overwrite"}, 64'(overwrite), 64'(m_ow));
      check({tag, ".a"}, 64'(a), 64'(m_slot[0]));
      check({tag, ".b"}, 64'(b), 64'(m_slot[1]));
      check({tag, ".c"}, 64'(c), 64'(m_slot[2]));
      check({tag, ".d"}, 64'(d), 64'(m_slot[3]));
   endtask

   // One clock: drive at negedge, apply the spec rules to the model, compare after the edge.
   task automatic cycle(input logic v, input logic [1:0] s, input logic signed [W-1:0] dt,
                        input logic o, input string tag);
      @(negedge clk);
      in_valid  = v;
      in_sel    = s;
      in_data   = dt;
      out_ready = o;
      if (!m_full) begin
         if (v) begin
            if (m_loaded[s]) m_ow = 1'b1;
            m_loaded[s] = 1'b1;
            m_slot[s]   = dt;
            if (m_loaded == 4'b1111) begin
               m_full = 1'b1;
               exp_q.push_back('{a: m_slot[0], b: m_slot[1], c: m_slot[2], d: m_slot[3], ow: m_ow});
            end
         end
      end else if (o) begin
         m_full   = 1'b0;
         m_loaded = 4'b0000;
         m_ow     = 1'b0;
      end
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all(tag);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
   endtask

   // Monitor: each rising out_valid must match the oldest queued operand set.
   logic ov_prev = 1'b0;
   always @(posedge clk) begin
      set_t e;
      #1;
      if (rst_n && out_valid && !ov_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL set_unexpected actual=out_valid expected=no_set at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("set.a", 64'(a), 64'(e.a));
            check("set.b", 64'(b), 64'(e.b));
            check("set.c", 64'(c), 64'(e.c));
            check("set.d", 64'(d), 64'(e.d));
            check("set.ow", 64'(overwrite), 64'(e.ow));
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      model_reset();
      // Reset held with a live word offered: nothing may be written.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_sel  = 2'($urandom);
         in_data = W'($urandom);
         #1;
         compare_all("reset");
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("reset.in_ready", 64'(in_ready), 64'(1'b1));

      // In-order fill, hold, handshake.
      cycle(1'b1, 2'd0, 16'shFFFF, 1'b0, "inord");
      cycle(1'b1, 2'd1, 16'shDFFF, 1'b0, "inord");
      cycle(1'b1, 2'd2, 16'shBFFF, 1'b0, "inord");
      cycle(1'b1, 2'd3, 16'sh7FFF, 1'b0, "inord");
      check("inord.a_val", 64'(a), 64'(-16'sd1));
      check("inord.c_val", 64'(c), 64'(-16'sd16385));
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, '0, 1'b0, "hold");
      cycle(1'b0, 2'd0, '0, 1'b1, "hs");
      cycle(1'b0, 2'd0, '0, 1'b0, "post_hs");

      // Out-of-order fill with an overwrite of slot d.
      cycle(1'b1, 2'd3, 16'sd5,     1'b0, "ooo");
      cycle(1'b1, 2'd1, -16'sd2,    1'b0, "ooo");
      cycle(1'b1, 2'd3, -16'sd7,    1'b0, "ooo");
      cycle(1'b1, 2'd0, 16'sd0,     1'b0, "ooo");
      cycle(1'b1, 2'd2, 16'sh8000,  1'b0, "ooo");
      check("ooo.overwrite", 64'(overwrite), 64'(1'b1));
      cycle(1'b0, 2'd0, '0, 1'b1, "ooo_hs");

      // Backpressure: refill, then hold a word against FULL until the handshake.
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), W'($urandom), 1'b0, "bp_fill");
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, 16'sd123, 1'b0, "bp_hold");
      cycle(1'b1, 2'd0, 16'sd123, 1'b1, "bp_hs");
      cycle(1'b1, 2'd0, 16'sd123, 1'b0, "bp_acc");
      check("bp.a123", 64'(a), 64'(16'sd123));
      check("bp.loaded", 64'(loaded), 64'(4'b0001));

      // Stalled upstream: gaps between words (slot a already fresh from above).
      for (int i = 1; i < 4; i++) begin
         cycle(1'b0, 2'(i), W'($urandom), 1'b0, "gap");
         cycle(1'b0, 2'(i), W'($urandom), 1'b0, "gap");
         cycle(1'b1, 2'(i), W'($urandom), 1'b0, "stall");
      end
      cycle(1'b0, 2'd0, '0, 1'b1, "stall_hs");

      // Reset after two accepts, then reset while FULL; each followed by a clean set.
      cycle(1'b1, 2'd2, 16'sd77, 1'b0, "mid");
      cycle(1'b1, 2'd0, -16'sd9, 1'b0, "mid");
      async_reset("rst_load");
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'(3 - i), W'($urandom), 1'b0, "refill");
      async_reset("rst_full");
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), W'($urandom), 1'b0, "refill2");
      cycle(1'b0, 2'd0, '0, 1'b1, "refill2_hs");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom),
               1'($urandom_range(0, 2) == 0), "rand");
      end
      cycle(1'b0, 2'd0, '0, 1'b1, "drain");
      cycle(1'b0, 2'd0, '0, 1'b0, "drain");

      check("scoreboard.empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/operand_demux.md
# operand_demux

Sequential 1-to-4 operand distributor for the expression solver datapath: accepts a stream of signed 16-bit words over a valid/ready handshake, each tagged with a 2-bit destination select, and latches them into four operand registers a, b, c, d. Once all four slots hold fresh values it presents them as one operand set to the downstream solver, which selects among them with the 4:1 operand mux. It is the write-side counterpart of that mux: it fills the slots the mux later reads.

## Interface
- WIDTH, 16, operand width in bits; operands are two's-complement signed.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_sel  input  2  destination slot: 00=a, 01=b, 10=c, 11=d.
- in_data  input  WIDTH  signed operand word.
- out_valid  output  1  operand set a..d complete and stable.
- out_ready  input  1  downstream consumes the operand set.
- a, b, c, d  output  WIDTH each  signed operand registers.
- loaded  output  4  per-slot fresh flags; bit i corresponds to in_sel value i.
- overwrite  output  1  sticky: a slot was written twice within the current set.

## Operation
- Two states: LOAD and FULL. Reset enters LOAD.
- LOAD: in_ready=1 and out_valid=0. A word is accepted on the rising edge where in_valid and in_ready are both 1.
- On acceptance:
  - Write in_data into the slot chosen by in_sel.
  - Set loaded[in_sel].
  - If loaded[in_sel] was already 1, set overwrite. The new value replaces the old one and the other slots are unaffected.
- Transition LOAD→FULL on the edge where an accepted word makes loaded == 4'b1111.
- FULL: in_ready=0 and out_valid=1. a..d, loaded and overwrite are held. in_valid is ignored.
- FULL→LOAD on the edge where out_ready=1. On that same edge:
  - loaded clears to 0000.
  - overwrite clears to 0.
  - a..d keep their values, since the solver may still be reading them.
- Slots may be filled in any order. No arithmetic is performed, and data passes bit-exact, sign included.
- in_sel and in_data are don't-care when in_valid=0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=LOAD.
  - a=b=c=d=0.
  - loaded=0000, overwrite=0, out_valid=0.
  - in_ready=1 once rst_n is high.
- in_ready and out_valid are decoded from the registered state only. There is no combinational path from in_valid or out_ready.
- Write latency: slot register and loaded bit update on the accepting edge and are visible the following cycle.
- out_valid rises one cycle after the 4th distinct slot is accepted, i.e. after the edge that accepts it.
- Minimum set period is 5 cycles: 4 accepts plus 1 FULL cycle with out_ready held high.
- Backpressure: a word offered while in FULL is not accepted. Upstream must hold it until in_ready returns, which is the cycle after the out_ready handshake.
- out_ready while in LOAD has no effect.
- Reset asserted mid-set (in LOAD or FULL) discards the partial or complete set immediately, including all operand values.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and random data → all outputs 0, loaded=0000, and no slot written. After release, in_ready=1.
- In-order fill: send sel 00..11 with 16'hFFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF on consecutive cycles, out_ready=0 → out_valid=1 one cycle after the 4th accept, with a=-1, b=-8193, c=-16385, d=32767 and in_ready=0. Hold for 3 cycles, then pulse out_ready → next cycle in_ready=1, loaded=0000, a..d unchanged.
- Out-of-order fill with overwrite: write sel 11=5, 01=-2, 11=-7, 00=0, 10=16'h8000 → out_valid after the 5th accept, with d=-7, c=-32768, overwrite=1. overwrite clears after the handshake.
- Backpressure: in FULL, hold in_valid=1, sel=00, data=123 for 4 cycles → a unchanged. After the handshake the word is accepted, so a=123 and loaded=0001.
- Stalled upstream: insert in_valid=0 gaps between the 4 words → out_valid rises only after the 4th accept, with no spurious writes during the gaps.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 accepts, and separately while in FULL → outputs reach reset values without a clock edge, and the next set loads cleanly.
